// File: rtl/uart_puf_sequencer.sv
// rtl/uart_puf_sequencer.sv - PUF challenge/response sequencer driving a single-bit UART TX and 64-bit RX
// Optional: define PUF_SEQ_PARITY_EN to append an even-parity frame after the challenge bits.
module uart_puf_sequencer #(
    parameter int CHAL_BITS   = 8,
    parameter int RESP_FRAMES = 8,
    parameter int RX_TIMEOUT  = 2000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CHAL_BITS-1:0] challenge,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err,
    output logic                 rx_err,
    output logic [63:0]          response,
    output logic                 uart_transmit,
    output logic [1:0]           uart_tx_bit,
    input  logic                 uart_is_transmitting,
    input  logic                 uart_received,
    input  logic [63:0]          uart_rx_byte,
    input  logic                 uart_recv_error
);

`ifdef PUF_SEQ_PARITY_EN
    localparam int NFRAMES = CHAL_BITS + 1;
`else
    localparam int NFRAMES = CHAL_BITS;
`endif
    localparam int BW = $clog2(NFRAMES + 1);
    localparam int TW = $clog2(RX_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, TX_REQ, TX_ACK, TX_WAIT, WAIT_RX, DONE, ERROR
    } state_t;

    state_t               state, state_nx;
    logic [NFRAMES-1:0]   shreg;
    logic [BW-1:0]        bit_cnt;
    logic [3:0]           frame_cnt;
    logic [TW-1:0]        tmo_cnt;

    logic last_bit, last_frame, tmo_hit;
    assign last_bit   = (bit_cnt == BW'(NFRAMES - 1));
    assign last_frame = (frame_cnt == 4'(RESP_FRAMES - 1));
    assign tmo_hit    = (tmo_cnt == TW'(RX_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = TX_REQ;
            TX_REQ:  if (!uart_is_transmitting) state_nx = TX_ACK;
            // Dropping transmit once the UART starts is what lets it leave recover.
            TX_ACK:  if (uart_is_transmitting) state_nx = TX_WAIT;
            TX_WAIT: if (!uart_is_transmitting) state_nx = last_bit ? WAIT_RX : TX_REQ;
            WAIT_RX: begin
                if (uart_recv_error)                  state_nx = ERROR;
                else if (uart_received && last_frame) state_nx = DONE;
                else if (!uart_received && tmo_hit)   state_nx = ERROR;
            end
            DONE:    state_nx = IDLE;
            ERROR:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign uart_transmit = (state == TX_REQ) || (state == TX_ACK);
    assign uart_tx_bit   = {1'b0, shreg[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            frame_cnt   <= '0;
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
            rx_err      <= 1'b0;
            response    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
`ifdef PUF_SEQ_PARITY_EN
                    shreg <= {^challenge, challenge};
`else
                    shreg <= challenge;
`endif
                    bit_cnt     <= '0;
                    frame_cnt   <= '0;
                    tmo_cnt     <= '0;
                    timeout_err <= 1'b0;
                    rx_err      <= 1'b0;
                end
                TX_WAIT: if (!uart_is_transmitting) begin
                    shreg   <= shreg >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    tmo_cnt <= '0;
                end
                WAIT_RX: begin
                    if (uart_recv_error) begin
                        rx_err <= 1'b1;
                    end else if (uart_received) begin
                        frame_cnt <= frame_cnt + 4'd1;
                        tmo_cnt   <= '0;
                        if (last_frame) response <= uart_rx_byte;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
